// File: rtl/collision_detector.sv
// Per-pixel collision stage: accumulates overlaps over a video frame and
// publishes one-cycle hit pulses at the next startOfFrame. Also tracks
// player lives, the post-hit invulnerability window and game_over.
module collision_detector #(
  parameter int unsigned NUM_MONSTERS  = 8,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned LIFE_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    playerDR,
  input  logic                    missileDR,
  input  logic [NUM_MONSTERS-1:0] monstersDR,
  input  logic                    obstacleDR,
  input  logic                    borderDR,
  output logic [NUM_MONSTERS-1:0] monster_hit,
  output logic                    missile_hit,
  output logic                    player_hit,
  output logic [LIFE_WIDTH-1:0]   lives,
  output logic                    game_over
);

  localparam int unsigned INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);

  logic [NUM_MONSTERS-1:0] pend_mon;
  logic                    pend_mis;
  logic                    pend_ply;
  logic [NUM_MONSTERS-1:0] ovl_mon;
  logic                    ovl_mis;
  logic                    ovl_ply;
  logic                    publish;
  logic                    ply_pub;
  logic [INV_W-1:0]        invuln;

  // Current-pixel overlaps and publish qualifiers
  always_comb begin
    ovl_mon = {NUM_MONSTERS{missileDR}} & monstersDR;
    ovl_mis = missileDR & ((|monstersDR) | obstacleDR | borderDR);
    ovl_ply = playerDR & (|monstersDR);
    publish = startOfFrame & ~game_over;
    ply_pub = publish & pend_ply & (invuln == '0);
  end

  // Pending flags: at frame start clear, but keep this cycle's overlaps
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_mon <= '0;
      pend_mis <= 1'b0;
      pend_ply <= 1'b0;
    end else if (game_over) begin
      pend_mon <= '0;
      pend_mis <= 1'b0;
      pend_ply <= 1'b0;
    end else if (startOfFrame) begin
      pend_mon <= ovl_mon;
      pend_mis <= ovl_mis;
      pend_ply <= ovl_ply;
    end else begin
      pend_mon <= pend_mon | ovl_mon;
      pend_mis <= pend_mis | ovl_mis;
      pend_ply <= pend_ply | ovl_ply;
    end
  end

  // One-cycle hit pulses following each frame start
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      monster_hit <= '0;
      missile_hit <= 1'b0;
      player_hit  <= 1'b0;
    end else begin
      monster_hit <= publish ? pend_mon : '0;
      missile_hit <= publish & pend_mis;
      player_hit  <= ply_pub;
    end
  end

  // Invulnerability window, counted in frames; frozen after game over
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      invuln <= '0;
    end else if (!game_over) begin
      if (ply_pub) begin
        invuln <= INV_W'(INVULN_FRAMES);
      end else if (startOfFrame && (invuln != '0)) begin
        invuln <= invuln - INV_W'(1);
      end
    end
  end

  // Lives decrement alongside the player_hit pulse, saturating at zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives <= LIFE_WIDTH'(LIVES);
    end else if (ply_pub && (lives != '0)) begin
      lives <= lives - LIFE_WIDTH'(1);
    end
  end

  // Sticky game_over, raised in the same cycle lives reaches zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      game_over <= 1'b0;
    end else if ((lives == '0) || (ply_pub && (lives <= LIFE_WIDTH'(1)))) begin
      game_over <= 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: each startOfFrame pushes the
// hand-computed publish result; a monitor compares on every cycle.
module tb_collision_detector;

  typedef struct packed {
    logic [7:0] mon;
    logic       mis;
    logic       ply;
    logic [1:0] lives;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       playerDR;
  logic       missileDR;
  logic [7:0] monstersDR;
  logic       obstacleDR;
  logic       borderDR;
  logic [7:0] monster_hit;
  logic       missile_hit;
  logic       player_hit;
  logic [1:0] lives;
  logic       game_over;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  collision_detector #(
    .NUM_MONSTERS(8), .LIVES(3), .INVULN_FRAMES(60), .LIFE_WIDTH(2)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .playerDR(playerDR), .missileDR(missileDR), .monstersDR(monstersDR),
    .obstacleDR(obstacleDR), .borderDR(borderDR),
    .monster_hit(monster_hit), .missile_hit(missile_hit),
    .player_hit(player_hit), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] mon, input logic mis, input logic ply,
                              input logic [1:0] lv, input logic go);
    exp_t e;
    e.mon = mon; e.mis = mis; e.ply = ply; e.lives = lv; e.go = go;
    return e;
  endfunction

  task automatic drive(input logic p, input logic m, input logic [7:0] mons,
                       input logic o, input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      startOfFrame = 1'b0;
      playerDR = p; missileDR = m; monstersDR = mons; obstacleDR = o; borderDR = b;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, n);
  endtask

  // Frame start; optional missile/monster overlap in the same cycle
  task automatic sof(input exp_t e, input logic m, input logic [7:0] mons);
    @(negedge clk);
    startOfFrame = 1'b1;
    playerDR = 1'b0; missileDR = m; monstersDR = mons; obstacleDR = 1'b0; borderDR = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: publish cycles pop the scoreboard, other cycles expect no pulses
  initial begin : monitor
    exp_t cur;
    exp_t got;
    exp_t e;
    logic pub;
    cur = mk(8'h00, 1'b0, 1'b0, 2'd3, 1'b0);
    forever begin
      @(posedge clk);
      pub = startOfFrame & resetN;
      #1;
      got = mk(monster_hit, missile_hit, player_hit, lives, game_over);
      if (pub) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL publish_no_expect t=%0t got=%h", $time, got);
        end else begin
          e = q.pop_front();
          cur = e;
          if (got !== e) begin
            n_err++;
            $display("FAIL publish t=%0t got mon=%h mis=%b ply=%b lives=%0d go=%b want mon=%h mis=%b ply=%b lives=%0d go=%b",
                     $time, got.mon, got.mis, got.ply, got.lives, got.go,
                     e.mon, e.mis, e.ply, e.lives, e.go);
          end
        end
      end else begin
        e = mk(8'h00, 1'b0, 1'b0, cur.lives, cur.go);
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL idle_cycle t=%0t got mon=%h mis=%b ply=%b lives=%0d go=%b want mon=%h mis=%b ply=%b lives=%0d go=%b",
                   $time, got.mon, got.mis, got.ply, got.lives, got.go,
                   e.mon, e.mis, e.ply, e.lives, e.go);
        end
      end
    end
  end

  initial begin : stim
    resetN = 1'b0; startOfFrame = 1'b0; playerDR = 1'b0; missileDR = 1'b0;
    monstersDR = 8'h00; obstacleDR = 1'b0; borderDR = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    idle(2);

    // Quiet frames
    sof(mk(8'h00, 0, 0, 2'd3, 0), 0, 8'h00);
    idle(5);
    sof(mk(8'h00, 0, 0, 2'd3, 0), 0, 8'h00);

    // Missile on monster 2 for 5 pixels -> single pulse, then quiet
    idle(3);
    drive(0, 1, 8'h04, 0, 0, 5);
    idle(3);
    sof(mk(8'h04, 1, 0, 2'd3, 0), 0, 8'h00);
    idle(4);
    sof(mk(8'h00, 0, 0, 2'd3, 0), 0, 8'h00);

    // Missile on border only
    drive(0, 1, 8'h00, 0, 1, 2);
    sof(mk(8'h00, 1, 0, 2'd3, 0), 0, 8'h00);

    // Several monsters at once; non-colliding combinations are harmless
    drive(0, 1, 8'hA1, 0, 0, 1);
    drive(1, 0, 8'h00, 1, 1, 2);
    drive(0, 1, 8'h00, 0, 0, 2);
    drive(0, 0, 8'hFF, 1, 1, 2);
    sof(mk(8'hA1, 1, 0, 2'd3, 0), 0, 8'h00);

    // Missile on obstacle only
    drive(0, 1, 8'h00, 1, 0, 1);
    sof(mk(8'h00, 1, 0, 2'd3, 0), 0, 8'h00);

    // Overlap during the startOfFrame cycle belongs to the new frame
    idle(2);
    sof(mk(8'h00, 0, 0, 2'd3, 0), 1, 8'h20);
    idle(2);
    sof(mk(8'h20, 1, 0, 2'd3, 0), 0, 8'h00);

    // Back-to-back frame starts
    drive(0, 1, 8'h02, 0, 0, 1);
    sof(mk(8'h02, 1, 0, 2'd3, 0), 0, 8'h00);
    drive(0, 1, 8'h08, 0, 0, 1);
    sof(mk(8'h08, 1, 0, 2'd3, 0), 0, 8'h00);
    sof(mk(8'h00, 0, 0, 2'd3, 0), 0, 8'h00);
    idle(2);

    // Reset mid-frame discards pending collisions
    drive(1, 1, 8'h01, 0, 0, 3);
    idle(1);
    resetN = 1'b0;
    idle(2);
    resetN = 1'b1;
    idle(2);
    sof(mk(8'h00, 0, 0, 2'd3, 0), 0, 8'h00);

    // Player hit, then suppressed during invulnerability
    drive(1, 0, 8'h01, 0, 0, 2);
    sof(mk(8'h00, 0, 1, 2'd2, 0), 0, 8'h00);
    drive(1, 0, 8'h01, 0, 0, 2);
    sof(mk(8'h00, 0, 0, 2'd2, 0), 0, 8'h00);
    for (int i = 0; i < 58; i++) begin
      idle(1);
      sof(mk(8'h00, 0, 0, 2'd2, 0), 0, 8'h00);
    end
    // Last invulnerable frame still suppresses, the next one does not
    drive(1, 0, 8'h01, 0, 0, 2);
    sof(mk(8'h00, 0, 0, 2'd2, 0), 0, 8'h00);
    drive(1, 0, 8'h01, 0, 0, 2);
    sof(mk(8'h00, 0, 1, 2'd1, 0), 0, 8'h00);

    // Third hit ends the game
    for (int i = 0; i < 60; i++) begin
      idle(1);
      sof(mk(8'h00, 0, 0, 2'd1, 0), 0, 8'h00);
    end
    drive(1, 0, 8'h80, 0, 0, 1);
    sof(mk(8'h00, 0, 1, 2'd0, 1), 0, 8'h00);

    // After game over nothing publishes
    drive(1, 1, 8'h0F, 1, 1, 3);
    sof(mk(8'h00, 0, 0, 2'd0, 1), 0, 8'h00);
    drive(1, 1, 8'hF0, 0, 1, 2);
    sof(mk(8'h00, 0, 0, 2'd0, 1), 0, 8'h00);
    idle(4);

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d entries left want=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Per-pixel collision stage that consumes the draw-request lines of the player, missile, monsters, obstacles and border.
- Accumulates overlaps over one video frame and publishes one-cycle hit pulses at the next startOfFrame.
- Downstream consumers are the monsters block (kill a monster), missiles (retire the missile) and player (lose a life).
- Also owns the player life counter, invulnerability window and game_over flag.

Parameters:
- NUM_MONSTERS, 8, number of monster draw-request lines and hit outputs.
- LIVES, 3, player lives loaded at reset.
- INVULN_FRAMES, 60, frames during which player hits are ignored after a player hit.
- LIFE_WIDTH, 2, width of the lives counter; must hold LIVES.

Ports:
- clk  in  1  system pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at frame start, from video timing.
- playerDR  in  1  player draws the current pixel.
- missileDR  in  1  missile draws the current pixel.
- monstersDR  in  NUM_MONSTERS  per-monster draw requests for the current pixel.
- obstacleDR  in  1  obstacle draws the current pixel.
- borderDR  in  1  pixel is on the playfield border.
- monster_hit  out  NUM_MONSTERS  one-cycle pulse per monster hit by the missile in the previous frame.
- missile_hit  out  1  one-cycle pulse when the missile touched any monster, obstacle or border in the previous frame.
- player_hit  out  1  one-cycle pulse when the player touched a monster in the previous frame and was not invulnerable.
- lives  out  LIFE_WIDTH  remaining lives.
- game_over  out  1  sticky; high once lives reach 0.

Behaviour:
- Reset (async, resetN=0): all pending flags cleared; monster_hit=0, missile_hit=0, player_hit=0, lives=LIVES, game_over=0, invuln counter=0. Reset mid-frame discards all pending collisions.
- Accumulate, every clk while game_over=0:
  - pend_mon[i] |= missileDR & monstersDR[i]
  - pend_mis |= missileDR & (|monstersDR | obstacleDR | borderDR)
  - pend_ply |= playerDR & |monstersDR
- Publish on the cycle where startOfFrame=1:
  - Outputs register monster_hit<=pend_mon, missile_hit<=pend_mis, player_hit<=pend_ply & (invuln==0). They are high exactly the cycle after startOfFrame and 0 otherwise.
  - Pending flags clear in the same cycle.
  - Overlaps sampled during the startOfFrame cycle go to the new frame's pending set (clear-then-set priority; not lost).
- Latency: a collision in frame N pulses 1 cycle after the startOfFrame that opens frame N+1. At most one pulse per signal per frame, regardless of how many overlapping pixels occur.
- Invulnerability:
  - When player_hit is issued, invuln loads INVULN_FRAMES.
  - Otherwise, on each startOfFrame with invuln>0, invuln decrements.
  - While invuln>0, pend_ply is discarded at publish.
- Lives:
  - On the cycle player_hit=1, lives decrements, saturating at 0.
  - game_over sets in the cycle lives becomes 0 and stays high until reset.
- After game_over=1:
  - Accumulation stops and all hit outputs stay 0.
  - lives holds 0 and invuln freezes.
- startOfFrame pulses back-to-back: each publishes independently; the second publishes only what accumulated in the one intervening cycle.
- Multiple monsters overlapping the missile in one frame all set their bits; missile_hit is a single pulse.
- LIVES=0 at reset: game_over asserts on the first clk after reset release.

Test Plan:
- After reset: lives=3, game_over=0, all hits 0; one frame with no DR activity -> no pulses.
- missileDR&monstersDR[2] high for 5 pixels mid-frame -> monster_hit=8'b00000100 and missile_hit=1 for exactly one cycle after next startOfFrame; 0 the following frame.
- missileDR&borderDR only -> missile_hit=1, monster_hit=0.
- playerDR&monstersDR[0] in frames 1, 2 and 62 with INVULN_FRAMES=60 -> player_hit after frame 1 (lives 3->2), suppressed after frame 2, pulses after frame 62 (lives 2->1).
- Three spaced player hits -> lives=0, game_over=1 sticky; further missile/monster overlaps produce no pulses.
- Overlap asserted in the same cycle as startOfFrame -> not published at that boundary, published at the following startOfFrame.
- resetN=0 mid-frame after an overlap -> no pulse at next startOfFrame, lives=3.
